// File: rtl/if_fetch_ctrl.sv
// Fetch-request sequencer: one outstanding SRAM-style request, flush cancellation,
// held output slot and exception bypass. Optional perf counters under IFC_PERF_CNT_EN.
module if_fetch_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_valid_i,
    input  logic [31:0] pc_i,
    input  logic        excep_i,
    output logic        pc_ready_o,
    input  logic        flush_i,
    output logic        inst_sram_req_o,
    output logic [31:0] inst_sram_addr_o,
    input  logic        inst_sram_addr_ok_i,
    input  logic        inst_sram_data_ok_i,
    input  logic [63:0] inst_sram_rdata_i,
    input  logic        next_allowin_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [63:0] if_inst_o,
    output logic        if_excep_o,
    output logic [31:0] perf_issue_cnt_o,
    output logic [31:0] perf_cancel_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CANCEL
    } state_t;

    state_t      state_q, state_d;
    logic        cancel_q, cancel_d;
    logic [31:0] pc_q;
    logic        slot_free;
    logic        handshake;
    logic        load_mem;
    logic        load_exc;
    logic        issue_evt;
    logic        discard_evt;

    assign slot_free        = !if_valid_o || next_allowin_i;
    assign handshake        = pc_valid_i && pc_ready_o;
    assign load_exc         = handshake && excep_i;
    assign inst_sram_req_o  = (state_q == ST_REQ);
    assign inst_sram_addr_o = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cancel_q <= 1'b0;
            pc_q     <= 32'h0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            if (handshake && !excep_i)
                pc_q <= pc_i;
        end
    end

    // Gating pc_ready_o with rst_n keeps every output low while reset is held.
    always_comb begin
        state_d     = state_q;
        cancel_d    = cancel_q;
        pc_ready_o  = 1'b0;
        load_mem    = 1'b0;
        issue_evt   = 1'b0;
        discard_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pc_ready_o = rst_n && slot_free && !flush_i;
                if (pc_valid_i && pc_ready_o && !excep_i)
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (inst_sram_addr_ok_i) begin
                    issue_evt = 1'b1;
                    state_d   = (cancel_q || flush_i) ? ST_CANCEL : ST_WAIT;
                end else if (flush_i) begin
                    cancel_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (inst_sram_data_ok_i) begin
                    state_d     = ST_IDLE;
                    load_mem    = !flush_i;
                    discard_evt = flush_i;
                end else if (flush_i) begin
                    state_d = ST_CANCEL;
                end
            end
            ST_CANCEL: begin
                if (inst_sram_data_ok_i) begin
                    state_d     = ST_IDLE;
                    discard_evt = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE || state_d == ST_CANCEL)
            cancel_d = 1'b0;
    end

    // A new load takes priority over draining; flush always empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_o <= 1'b0;
            if_pc_o    <= 32'h0;
            if_inst_o  <= 64'h0;
            if_excep_o <= 1'b0;
        end else if (flush_i) begin
            if_valid_o <= 1'b0;
            if_pc_o    <= 32'h0;
            if_inst_o  <= 64'h0;
            if_excep_o <= 1'b0;
        end else if (load_mem) begin
            if_valid_o <= 1'b1;
            if_pc_o    <= pc_q;
            if_inst_o  <= inst_sram_rdata_i;
            if_excep_o <= 1'b0;
        end else if (load_exc) begin
            if_valid_o <= 1'b1;
            if_pc_o    <= pc_i;
            if_inst_o  <= 64'h0;
            if_excep_o <= 1'b1;
        end else if (if_valid_o && next_allowin_i) begin
            if_valid_o <= 1'b0;
            if_pc_o    <= 32'h0;
            if_inst_o  <= 64'h0;
            if_excep_o <= 1'b0;
        end
    end

`ifdef IFC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt_o  <= 32'h0;
            perf_cancel_cnt_o <= 32'h0;
        end else begin
            if (issue_evt)
                perf_issue_cnt_o <= perf_issue_cnt_o + 32'd1;
            if (discard_evt)
                perf_cancel_cnt_o <= perf_cancel_cnt_o + 32'd1;
        end
    end
`else
    logic unused_evt;
    assign unused_evt        = issue_evt ^ discard_evt;
    assign perf_issue_cnt_o  = 32'h0;
    assign perf_cancel_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed vector bench for if_fetch_ctrl: one table row per clock cycle, plus an
// async-reset-in-WAIT sequence. Counter expectations collapse to 0 without IFC_PERF_CNT_EN.
module tb_if_fetch_ctrl;

`ifdef IFC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        pc_valid_i;
    logic [31:0] pc_i;
    logic        excep_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        inst_sram_req_o;
    logic [31:0] inst_sram_addr_o;
    logic        inst_sram_addr_ok_i;
    logic        inst_sram_data_ok_i;
    logic [63:0] inst_sram_rdata_i;
    logic        next_allowin_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [63:0] if_inst_o;
    logic        if_excep_o;
    logic [31:0] perf_issue_cnt_o;
    logic [31:0] perf_cancel_cnt_o;

    int errors = 0;
    int checks = 0;

    if_fetch_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pc_valid_i          (pc_valid_i),
        .pc_i                (pc_i),
        .excep_i             (excep_i),
        .pc_ready_o          (pc_ready_o),
        .flush_i             (flush_i),
        .inst_sram_req_o     (inst_sram_req_o),
        .inst_sram_addr_o    (inst_sram_addr_o),
        .inst_sram_addr_ok_i (inst_sram_addr_ok_i),
        .inst_sram_data_ok_i (inst_sram_data_ok_i),
        .inst_sram_rdata_i   (inst_sram_rdata_i),
        .next_allowin_i      (next_allowin_i),
        .if_valid_o          (if_valid_o),
        .if_pc_o             (if_pc_o),
        .if_inst_o           (if_inst_o),
        .if_excep_o          (if_excep_o),
        .perf_issue_cnt_o    (perf_issue_cnt_o),
        .perf_cancel_cnt_o   (perf_cancel_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        ex;
        logic        fl;
        logic        aok;
        logic        dok;
        logic [63:0] rdata;
        logic        nal;
        logic        e_rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [63:0] e_inst;
        logic        e_ex;
        logic [31:0] e_iss;
        logic [31:0] e_can;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] R1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] R2 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] R3 = 64'hdead_beef_0bad_f00d;
    localparam logic [63:0] R4 = 64'hcafe_babe_1234_5678;
    localparam logic [63:0] R5 = 64'h0f0f_0f0f_f0f0_f0f0;

    task automatic addVec(input logic pv, input logic [31:0] pc, input logic ex,
                          input logic fl, input logic aok, input logic dok,
                          input logic [63:0] rdata, input logic nal,
                          input logic e_rdy, input logic e_req, input logic [31:0] e_addr,
                          input logic e_vld, input logic [31:0] e_pc, input logic [63:0] e_inst,
                          input logic e_ex, input logic [31:0] e_iss, input logic [31:0] e_can);
        vec_t v;
        v.pv = pv; v.pc = pc; v.ex = ex; v.fl = fl; v.aok = aok; v.dok = dok;
        v.rdata = rdata; v.nal = nal;
        v.e_rdy = e_rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_ex = e_ex; v.e_iss = e_iss; v.e_can = e_can;
        vecs.push_back(v);
    endtask

    task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        pc_valid_i          = v.pv;
        pc_i                = v.pc;
        excep_i             = v.ex;
        flush_i             = v.fl;
        inst_sram_addr_ok_i = v.aok;
        inst_sram_data_ok_i = v.dok;
        inst_sram_rdata_i   = v.rdata;
        next_allowin_i      = v.nal;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        checkField({p, ".pc_ready"}, 64'(pc_ready_o), 64'(v.e_rdy));
        checkField({p, ".req"}, 64'(inst_sram_req_o), 64'(v.e_req));
        checkField({p, ".addr"}, 64'(inst_sram_addr_o), 64'(v.e_addr));
        checkField({p, ".if_valid"}, 64'(if_valid_o), 64'(v.e_vld));
        checkField({p, ".if_pc"}, 64'(if_pc_o), 64'(v.e_pc));
        checkField({p, ".if_inst"}, if_inst_o, v.e_inst);
        checkField({p, ".if_excep"}, 64'(if_excep_o), 64'(v.e_ex));
        checkField({p, ".issue_cnt"}, 64'(perf_issue_cnt_o), PERF ? 64'(v.e_iss) : 64'h0);
        checkField({p, ".cancel_cnt"}, 64'(perf_cancel_cnt_o), PERF ? 64'(v.e_can) : 64'h0);
    endtask

    task automatic checkAllZero(input string p);
        checkField({p, ".pc_ready"}, 64'(pc_ready_o), 64'h0);
        checkField({p, ".req"}, 64'(inst_sram_req_o), 64'h0);
        checkField({p, ".addr"}, 64'(inst_sram_addr_o), 64'h0);
        checkField({p, ".if_valid"}, 64'(if_valid_o), 64'h0);
        checkField({p, ".if_pc"}, 64'(if_pc_o), 64'h0);
        checkField({p, ".if_inst"}, if_inst_o, 64'h0);
        checkField({p, ".if_excep"}, 64'(if_excep_o), 64'h0);
        checkField({p, ".issue_cnt"}, 64'(perf_issue_cnt_o), 64'h0);
        checkField({p, ".cancel_cnt"}, 64'(perf_cancel_cnt_o), 64'h0);
    endtask

    initial begin
        // Rows: pv pc ex fl aok dok rdata nal | rdy req addr vld if_pc inst iex iss can
        addVec(0, 32'h0,        0,0,0,0, 64'h0, 1,  1,0,32'h0,        0,32'h0,        64'h0,0, 0,0);
        // Plain fetch, addr_ok with req, data_ok next; then 5-cycle stall
        addVec(1, 32'h1c000000, 0,0,0,0, 64'h0, 1,  1,0,32'h0,        0,32'h0,        64'h0,0, 0,0);
        addVec(0, 32'h0,        0,0,1,0, 64'h0, 1,  0,1,32'h1c000000, 0,32'h0,        64'h0,0, 0,0);
        addVec(0, 32'h0,        0,0,0,1, R1,    0,  0,0,32'h1c000000, 0,32'h0,        64'h0,0, 1,0);
        for (int i = 0; i < 5; i++)
            addVec(1, 32'h1c000008, 0,0,0,0, 64'h0, 0,  0,0,32'h1c000000, 1,32'h1c000000, R1,0, 1,0);
        // Release: slot drains and the next PC is accepted in the same cycle
        addVec(1, 32'h1c000008, 0,0,0,0, 64'h0, 1,  1,0,32'h1c000000, 1,32'h1c000000, R1,0, 1,0);
        addVec(0, 32'h0,        0,0,1,0, 64'h0, 1,  0,1,32'h1c000008, 0,32'h0,        64'h0,0, 1,0);
        addVec(0, 32'h0,        0,0,0,1, R2,    1,  0,0,32'h1c000008, 0,32'h0,        64'h0,0, 2,0);
        addVec(0, 32'h0,        0,0,0,0, 64'h0, 1,  1,0,32'h1c000008, 1,32'h1c000008, R2,0, 2,0);
        addVec(0, 32'h0,        0,0,0,0, 64'h0, 1,  1,0,32'h1c000008, 0,32'h0,        64'h0,0, 2,0);
        // Flush in first REQ cycle, addr_ok 3 cycles late, data discarded
        addVec(1, 32'h1c000010, 0,0,0,0, 64'h0, 1,  1,0,32'h1c000008, 0,32'h0,        64'h0,0, 2,0);
        addVec(0, 32'h0,        0,1,0,0, 64'h0, 1,  0,1,32'h1c000010, 0,32'h0,        64'h0,0, 2,0);
        addVec(0, 32'h0,        0,0,0,0, 64'h0, 1,  0,1,32'h1c000010, 0,32'h0,        64'h0,0, 2,0);
        addVec(0, 32'h0,        0,0,0,0, 64'h0, 1,  0,1,32'h1c000010, 0,32'h0,        64'h0,0, 2,0);
        addVec(0, 32'h0,        0,0,1,0, 64'h0, 1,  0,1,32'h1c000010, 0,32'h0,        64'h0,0, 2,0);
        addVec(0, 32'h0,        0,0,0,1, R3,    1,  0,0,32'h1c000010, 0,32'h0,        64'h0,0, 3,0);
        // Flush coincident with data_ok in WAIT
        addVec(1, 32'h1c000020, 0,0,0,0, 64'h0, 1,  1,0,32'h1c000010, 0,32'h0,        64'h0,0, 3,1);
        addVec(0, 32'h0,        0,0,1,0, 64'h0, 1,  0,1,32'h1c000020, 0,32'h0,        64'h0,0, 3,1);
        addVec(0, 32'h0,        0,1,0,1, R4,    1,  0,0,32'h1c000020, 0,32'h0,        64'h0,0, 4,1);
        addVec(0, 32'h0,        0,0,0,0, 64'h0, 1,  1,0,32'h1c000020, 0,32'h0,        64'h0,0, 4,2);
        // Flush in WAIT without data -> CANCEL, later data_ok discarded
        addVec(1, 32'h1c000030, 0,0,0,0, 64'h0, 1,  1,0,32'h1c000020, 0,32'h0,        64'h0,0, 4,2);
        addVec(0, 32'h0,        0,0,1,0, 64'h0, 1,  0,1,32'h1c000030, 0,32'h0,        64'h0,0, 4,2);
        addVec(0, 32'h0,        0,1,0,0, 64'h0, 1,  0,0,32'h1c000030, 0,32'h0,        64'h0,0, 5,2);
        addVec(0, 32'h0,        0,1,0,1, R5,    1,  0,0,32'h1c000030, 0,32'h0,        64'h0,0, 5,2);
        // Flush in IDLE blocks acceptance
        addVec(1, 32'h1c000040, 0,1,0,0, 64'h0, 1,  0,0,32'h1c000030, 0,32'h0,        64'h0,0, 5,3);
        addVec(0, 32'h0,        0,0,0,0, 64'h0, 1,  1,0,32'h1c000030, 0,32'h0,        64'h0,0, 5,3);
        // Exception bypass: no request, output valid next cycle
        addVec(1, 32'h1c000002, 1,0,0,0, 64'h0, 1,  1,0,32'h1c000030, 0,32'h0,        64'h0,0, 5,3);
        addVec(0, 32'h0,        0,0,0,0, 64'h0, 1,  1,0,32'h1c000030, 1,32'h1c000002, 64'h0,1, 5,3);
        addVec(0, 32'h0,        0,0,0,0, 64'h0, 1,  1,0,32'h1c000030, 0,32'h0,        64'h0,0, 5,3);
        // Held exception fetch cleared by flush
        addVec(1, 32'h1c000004, 1,0,0,0, 64'h0, 1,  1,0,32'h1c000030, 0,32'h0,        64'h0,0, 5,3);
        addVec(0, 32'h0,        0,1,0,0, 64'h0, 0,  0,0,32'h1c000030, 1,32'h1c000004, 64'h0,1, 5,3);
        addVec(0, 32'h0,        0,0,0,0, 64'h0, 0,  1,0,32'h1c000030, 0,32'h0,        64'h0,0, 5,3);

        applyStimulus(vecs[0]);
        rst_n = 1'b0;
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(i, vecs[i]);
        end

        // Async reset while in WAIT, then a late data_ok must be ignored
        @(negedge clk);
        pc_valid_i = 1'b1; pc_i = 32'h1c000050; excep_i = 1'b0; flush_i = 1'b0;
        inst_sram_addr_ok_i = 1'b0; inst_sram_data_ok_i = 1'b0; next_allowin_i = 1'b1;
        @(negedge clk);
        pc_valid_i = 1'b0; inst_sram_addr_ok_i = 1'b1;
        #1;
        checkField("rst.pre_req", 64'(inst_sram_req_o), 64'h1);
        @(negedge clk);
        inst_sram_addr_ok_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_in_wait");
        @(negedge clk);
        rst_n = 1'b1;
        inst_sram_data_ok_i = 1'b1;
        inst_sram_rdata_i = R1;
        #1;
        checkField("rst.late_rdy", 64'(pc_ready_o), 64'h1);
        @(negedge clk);
        inst_sram_data_ok_i = 1'b0;
        #1;
        checkField("rst.late_valid", 64'(if_valid_o), 64'h0);
        checkField("rst.late_inst", if_inst_o, 64'h0);
        checkField("rst.late_req", 64'(inst_sram_req_o), 64'h0);
        checkField("rst.cancel_cnt", 64'(perf_cancel_cnt_o), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch-request sequencer between the pre-IF stage and the instruction SRAM/cache port. It accepts one fetch PC at a time, drives the SRAM-like request handshake (req/addr_ok/data_ok) and cancels in-flight requests on pipeline flush so stale data never reaches IF. It also holds the returned 64-bit instruction pair in an output register until the IF stage takes it, and bypasses the memory port entirely for PCs already marked with a fetch exception.

## Interface
- No parameters; PC width 32, fetch data width 64 (two instructions, pc1 in [31:0], pc2 in [63:32]).
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_valid_i  in  1  pre-IF presents a fetch PC
- pc_i  in  32  fetch PC (pc1)
- excep_i  in  1  this PC already carries a fetch exception; no memory access
- pc_ready_o  out  1  PC accepted this cycle (handshake = pc_valid_i & pc_ready_o)
- flush_i  in  1  exception or branch flush (OR of both)
- inst_sram_req_o  out  1  request to instruction memory
- inst_sram_addr_o  out  32  request address
- inst_sram_addr_ok_i  in  1  address accepted by memory
- inst_sram_data_ok_i  in  1  read data valid
- inst_sram_rdata_i  in  64  read data
- next_allowin_i  in  1  IF stage accepts output this cycle
- if_valid_o  out  1  output register holds a valid fetch
- if_pc_o  out  32  PC of held fetch
- if_inst_o  out  64  held instruction pair (0 for exception fetches)
- if_excep_o  out  1  held fetch is an exception bypass
- perf_issue_cnt_o  out  32  issued requests (only with IFC_PERF_CNT_EN)
- perf_cancel_cnt_o  out  32  cancelled requests (only with IFC_PERF_CNT_EN)

## Operation
- At most one outstanding memory request. States: IDLE, REQ, WAIT, CANCEL.
- Output slot free = !if_valid_o || next_allowin_i.
- IDLE: pc_ready_o = slot free & !flush_i. On handshake with excep_i=0: latch pc_i, go REQ. With excep_i=1: load output register next edge (if_valid_o=1, if_excep_o=1, if_inst_o=0, if_pc_o=pc_i), stay IDLE.
- REQ: inst_sram_req_o=1, inst_sram_addr_o=latched PC (held stable). addr_ok -> WAIT, or CANCEL if cancel flag set or flush_i this cycle. flush_i without addr_ok sets cancel flag; req stays asserted (no withdrawal before addr_ok).
- WAIT: data_ok & !flush_i -> load output register (if_excep_o=0), go IDLE. data_ok & flush_i -> discard, IDLE. flush_i without data_ok -> CANCEL.
- CANCEL: data_ok -> discard, IDLE; flush_i ignored.
- pc_ready_o=0 in REQ, WAIT, CANCEL.
- Output register: cleared when flush_i; else cleared when if_valid_o & next_allowin_i and no new load; load wins over drain in the same cycle. Acceptance rule guarantees the slot is empty when data_ok arrives.
- Cancel flag cleared on entry to CANCEL or IDLE.

## Timing
- Reset: state IDLE, cancel flag 0, every output 0 (pc_ready_o, inst_sram_req_o, inst_sram_addr_o, if_valid_o, if_pc_o, if_inst_o, if_excep_o, counters).
- PC accepted at edge T: req high in cycle T+1; earliest addr_ok T+1, earliest data_ok T+2; if_valid_o high in cycle T+3. Next PC accepted in IDLE cycle T+3 earliest; peak throughput one fetch per 3 cycles.
- Exception bypass: accepted at T -> if_valid_o in T+1, no req.
- flush_i in any cycle: if_valid_o low next cycle; no data from a request issued or addr-accepted before the flush is ever loaded.
- All outputs registered except pc_ready_o (combinational from state, if_valid_o, next_allowin_i, flush_i).

## Configuration
- IFC_PERF_CNT_EN defined: two 32-bit wrap-around counters; perf_issue_cnt_o +1 per addr_ok, perf_cancel_cnt_o +1 per discarded data_ok (WAIT-with-flush or CANCEL). Reset to 0.
- Not defined: counter ports tied to 32'h0, no counter flops.

## Test plan
- Plain fetch: pc_i=0x1c000000, addr_ok same cycle as req, data_ok next -> if_valid_o=1, if_pc_o=0x1c000000, if_inst_o=rdata, if_excep_o=0.
- Stall: next_allowin_i=0 for 5 cycles after output loads -> output held, pc_ready_o=0, no new req; release -> slot drains, next PC accepted same cycle.
- Flush in REQ: addr_ok delayed 3 cycles, flush_i in first REQ cycle -> req held until addr_ok, data_ok discarded, if_valid_o stays 0, cancel count =1.
- Flush coincident with data_ok in WAIT -> data discarded, state IDLE, if_valid_o=0 next cycle.
- Exception bypass: pc_i=0x1c000002, excep_i=1 -> no req, if_valid_o=1 next cycle, if_excep_o=1, if_inst_o=0.
- Async reset asserted in WAIT -> all outputs 0 immediately; after release a late data_ok is ignored in IDLE.
